wdg_reset_unit: RTL and testbench



---
 rtl/wdg_pkg.sv | 34 +++
 rtl/wdg_rst_seq.sv | 68 ++++++
 rtl/wdg_reset_unit.sv | 126 ++++++++++++
 tb/tb_wdg_reset_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wdg_pkg.sv
// Shared definitions for the two-stage watchdog: register offsets, WDCSR
// field layout and the reset-sequencer state encoding.
package wdg_pkg;

    localparam int WDCSR_OFF = 'h0;
    localparam int WDCNT_OFF = 'h4;

    localparam int CSR_EN_BIT  = 0;
    localparam int CSR_S1_BIT  = 1;
    localparam int CSR_S2_BIT  = 2;
    localparam int CSR_WTO_LSB = 4;
    localparam int WTO_W       = 10;

    localparam logic [WTO_W-1:0] WTO_RST = '1;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_CORE_HOLD,
        SEQ_PAD,
        SEQ_WDG_RST
    } seq_state_t;

    function automatic logic [31:0] pack_csr(input logic en, input logic s1,
                                             input logic s2, input logic [WTO_W-1:0] wto);
        logic [31:0] w;
        w = '0;
        w[CSR_EN_BIT] = en;
        w[CSR_S1_BIT] = s1;
        w[CSR_S2_BIT] = s2;
        w[CSR_WTO_LSB +: WTO_W] = wto;
        return w;
    endfunction

endpackage

// File: rtl/wdg_rst_seq.sv
// Reset sequencer: on a stage-2 timeout holds the core in reset, waits a pad
// gap, then pulses the watchdog self-reset before returning to idle.
module wdg_rst_seq
    import wdg_pkg::*;
#(
    parameter int CORE_RST_CYCLES = 60,
    parameter int PADDING_CYCLES  = 1,
    parameter int WDG_RST_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       s2wto,
    output logic       core_rst,
    output seq_state_t state
);

    localparam int CW = 16;

    logic [CW-1:0] cnt;

    // cnt holds the remaining cycles of the current phase minus one.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state <= SEQ_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (s2wto) begin
                        state <= SEQ_CORE_HOLD;
                        cnt   <= CW'(CORE_RST_CYCLES - 1);
                    end
                end
                SEQ_CORE_HOLD: begin
                    if (cnt == '0) begin
                        state <= SEQ_PAD;
                        cnt   <= CW'(PADDING_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SEQ_PAD: begin
                    if (cnt == '0) begin
                        state <= SEQ_WDG_RST;
                        cnt   <= CW'(WDG_RST_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SEQ_WDG_RST: begin
                    if (cnt == '0) begin
                        state <= SEQ_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign core_rst = sys_rst | (state != SEQ_IDLE);

endmodule

// File: rtl/wdg_reset_unit.sv
// Two-stage watchdog with a pipelined Wishbone register port; a second missed
// period triggers the sequenced core reset and a watchdog self-reset.
module wdg_reset_unit
    import wdg_pkg::*;
#(
    parameter int REG_ADDRESS_WIDTH = 4,
    parameter int REG_BASE_ADDRESS  = 0,
    parameter int WB_DATA_WIDTH     = 32,
    parameter int WDG_TICK_BIT      = 2,
    parameter int CORE_RST_CYCLES   = 60,
    parameter int PADDING_CYCLES    = 1,
    parameter int WDG_RST_CYCLES    = 1
) (
    input  logic                         clk,
    input  logic                         sys_rst,
    input  logic                         i_wb_cyc,
    input  logic                         i_wb_stb,
    input  logic                         i_wb_we,
    input  logic [REG_ADDRESS_WIDTH-1:0] i_wb_adr,
    input  logic [WB_DATA_WIDTH-1:0]     i_wb_dat,
    input  logic [WB_DATA_WIDTH/8-1:0]   i_wb_sel,
    output logic                         o_wb_stall,
    output logic                         o_wb_ack,
    output logic                         o_wb_err,
    output logic                         o_wb_rty,
    output logic [WB_DATA_WIDTH-1:0]     o_wb_dat,
    output logic                         o_irq1,
    output logic                         o_irq2,
    output logic                         o_core_rst
);

    localparam logic [REG_ADDRESS_WIDTH-1:0] CSR_ADR = REG_ADDRESS_WIDTH'(REG_BASE_ADDRESS + WDCSR_OFF);
    localparam logic [REG_ADDRESS_WIDTH-1:0] CNT_ADR = REG_ADDRESS_WIDTH'(REG_BASE_ADDRESS + WDCNT_OFF);

    logic              en, s1, s2;
    logic [WTO_W-1:0]  wto, cnt;
    logic [WDG_TICK_BIT-1:0] pre;
    logic              ack_q;
    logic              accept, wr_csr, tick, wdg_srst;
    logic              new_en;
    logic [WTO_W-1:0]  new_wto;
    logic [31:0]       rd_mux;
    seq_state_t        seq_state;
    logic              unused_bits;

    // Handshake: a request is taken when cyc & stb & !stall; ack follows one
    // cycle later with read data, and stall covers that cycle so only one
    // request is ever outstanding.
    assign accept = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr_csr = accept & i_wb_we & (i_wb_adr == CSR_ADR);
    assign tick   = &pre;

    assign new_en        = i_wb_sel[0] ? i_wb_dat[0]    : en;
    assign new_wto[3:0]  = i_wb_sel[0] ? i_wb_dat[7:4]  : wto[3:0];
    assign new_wto[9:4]  = i_wb_sel[1] ? i_wb_dat[13:8] : wto[9:4];
    assign unused_bits   = ^{i_wb_dat[WB_DATA_WIDTH-1:14], i_wb_dat[3:1], i_wb_sel[3:2]};

    always_comb begin
        rd_mux = '0;
        if (i_wb_adr == CSR_ADR)      rd_mux = pack_csr(en, s1, s2, wto);
        else if (i_wb_adr == CNT_ADR) rd_mux = {22'b0, cnt};
    end

    always_ff @(posedge clk) begin
        if (sys_rst || wdg_srst) begin
            en  <= 1'b0;
            wto <= WTO_RST;
            cnt <= '0;
            pre <= '0;
            s1  <= 1'b0;
            s2  <= 1'b0;
        end else if (wr_csr) begin
            // A refresh beats any tick or stage event landing on the same edge.
            en  <= new_en;
            wto <= new_wto;
            cnt <= '0;
            pre <= '0;
            s1  <= 1'b0;
        end else if (en) begin
            pre <= pre + 1'b1;
            if (tick) begin
                if (cnt >= wto) begin
                    cnt <= '0;
                    if (!s1) s1 <= 1'b1;
                    else     s2 <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin
            cnt <= '0;
            pre <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            ack_q    <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            ack_q <= accept;
            if (accept) o_wb_dat <= i_wb_we ? '0 : rd_mux;
        end
    end

    wdg_rst_seq #(
        .CORE_RST_CYCLES(CORE_RST_CYCLES),
        .PADDING_CYCLES (PADDING_CYCLES),
        .WDG_RST_CYCLES (WDG_RST_CYCLES)
    ) u_seq (
        .clk     (clk),
        .sys_rst (sys_rst),
        .s2wto   (s2),
        .core_rst(o_core_rst),
        .state   (seq_state)
    );

    assign wdg_srst   = (seq_state == SEQ_WDG_RST);
    assign o_wb_ack   = ack_q;
    assign o_wb_stall = ack_q;
    assign o_wb_err   = 1'b0;
    assign o_wb_rty   = 1'b0;
    assign o_irq1     = s1;
    assign o_irq2     = s2;

endmodule

// File: tb/tb_wdg_reset_unit.sv
// Directed and randomized bench for wdg_reset_unit with a cycle-level
// behavioural model of the watchdog rules and the reset window.
module tb_wdg_reset_unit;

    localparam int TICK_BIT  = 2;
    localparam int TICK_MAX  = (1 << TICK_BIT) - 1;
    localparam int CORE      = 60;
    localparam int PADC      = 1;
    localparam int WRST      = 1;
    localparam int TOTAL     = CORE + PADC + WRST;

    logic        clk_tb = 1'b0;
    logic        sys_rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        o_wb_stall, o_wb_ack, o_wb_err, o_wb_rty;
    logic [31:0] o_wb_dat;
    logic        o_irq1, o_irq2, o_core_rst;

    always #5 clk_tb = ~clk_tb;

    wdg_reset_unit #(
        .REG_ADDRESS_WIDTH(4), .REG_BASE_ADDRESS(0), .WB_DATA_WIDTH(32),
        .WDG_TICK_BIT(TICK_BIT), .CORE_RST_CYCLES(CORE),
        .PADDING_CYCLES(PADC), .WDG_RST_CYCLES(WRST)
    ) dut (
        .clk(clk_tb), .sys_rst(sys_rst),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_wb_rty(o_wb_rty), .o_wb_dat(o_wb_dat),
        .o_irq1(o_irq1), .o_irq2(o_irq2), .o_core_rst(o_core_rst)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int acc_cycle = 0;
    bit mon_on = 1'b0;

    logic       m_en = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0, m_srst = 1'b0;
    logic [9:0] m_wto = 10'h3FF;
    int         m_cnt = 0, m_pre = 0, m_left = 0;
    logic [31:0] m_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] adr);
        if (adr == 4'h0) return {18'b0, m_wto, 1'b0, m_s2, m_s1, m_en};
        if (adr == 4'h4) return 32'(m_cnt);
        return 32'h0;
    endfunction

    // m_left counts the remaining cycles of the core-reset window; the
    // watchdog self-reset lands on its last WRST edges.
    always @(posedge clk_tb) begin
        cyc_cnt++;
        m_srst = 1'b0;
        if (sys_rst) m_left = 0;
        else if (m_left > 0) begin
            m_srst = (m_left <= WRST);
            m_left--;
        end else if (m_s2) m_left = TOTAL;

        if (sys_rst || m_srst) begin
            m_en = 0; m_wto = 10'h3FF; m_cnt = 0; m_pre = 0; m_s1 = 0; m_s2 = 0;
        end else if (wb_cyc && wb_stb && wb_we && wb_adr == 4'h0) begin
            m_w = model_read(4'h0);
            for (int b = 0; b < 4; b++) if (wb_sel[b]) m_w[8*b +: 8] = wb_dat[8*b +: 8];
            m_en = m_w[0]; m_wto = m_w[13:4]; m_cnt = 0; m_pre = 0; m_s1 = 0;
        end else if (m_en) begin
            if (m_pre == TICK_MAX) begin
                m_pre = 0;
                if (m_cnt == int'(m_wto)) begin
                    m_cnt = 0;
                    if (!m_s1) m_s1 = 1; else m_s2 = 1;
                end else m_cnt++;
            end else m_pre++;
        end else begin
            m_cnt = 0; m_pre = 0;
        end
    end

    always @(negedge clk_tb) begin
        if (mon_on) begin
            chk("irq1", 32'(o_irq1), 32'(m_s1));
            chk("irq2", 32'(o_irq2), 32'(m_s2));
            chk("core_rst", 32'(o_core_rst), 32'(sys_rst || m_left > 0));
            chk("err_rty", {30'b0, o_wb_err, o_wb_rty}, 32'h0);
        end
    end

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        logic [31:0] exp;
        @(negedge clk_tb);
        chk("stall_idle", 32'(o_wb_stall), 32'h0);
        chk("ack_idle", 32'(o_wb_ack), 32'h0);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat = wdat; wb_sel = sel;
        exp = model_read(adr);
        @(posedge clk_tb);
        #1;
        acc_cycle = cyc_cnt;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(negedge clk_tb);
        chk("ack_pulse", 32'(o_wb_ack), 32'h1);
        chk("stall_pending", 32'(o_wb_stall), 32'h1);
        if (!we) chk("rdata", o_wb_dat, exp);
        rdat = o_wb_dat;
        @(negedge clk_tb);
        chk("ack_drop", 32'(o_wb_ack), 32'h0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: observed time %0t expected completion", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] rd, d;
        int w0, t1, t2, r, n, op;
        logic [3:0] a;

        // Reset and read-back
        repeat (3) @(negedge clk_tb);
        mon_on = 1;
        sys_rst = 0;
        wb_xfer(0, 4'h0, 0, 4'hF, rd); chk("rst_csr", rd, 32'h3FF0);
        wb_xfer(0, 4'h4, 0, 4'hF, rd); chk("rst_cnt", rd, 32'h0);

        // Count progression, WTOCNT=16
        wb_xfer(1, 4'h0, 32'h101, 4'hF, rd);
        w0 = acc_cycle;
        repeat (8) begin
            repeat ($urandom_range(0, 4)) @(negedge clk_tb);
            wb_xfer(0, 4'h4, 0, 4'hF, rd);
            if (acc_cycle - w0 <= 64) chk("cnt_prog", rd, 32'((acc_cycle - 1 - w0) / 4));
            chk("cnt_max", 32'(rd <= 16), 32'h1);
        end

        // Periodic refresh keeps both stages quiet
        repeat (12) begin
            wb_xfer(1, 4'h0, 32'h101, 4'hF, rd);
            wb_xfer(0, 4'h4, 0, 4'hF, rd);
            chk("cnt_restart", rd, 32'h0);
            repeat (34) @(negedge clk_tb);
            chk("refresh_irq", {30'b0, o_irq1, o_irq2}, 32'h0);
        end

        // Stage 1
        wb_xfer(1, 4'h0, 32'h101, 4'hF, rd);
        w0 = acc_cycle; t1 = -1;
        for (int i = 0; i < 200 && t1 < 0; i++) begin
            @(negedge clk_tb);
            if (o_irq1) t1 = cyc_cnt;
        end
        chk("irq1_latency", 32'(t1 - w0), 32'd68);
        wb_xfer(0, 4'h0, 0, 4'hF, rd); chk("csr_s1", rd, 32'h103);

        // Stage 2 and the reset sequence
        t2 = -1;
        for (int i = 0; i < 200 && t2 < 0; i++) begin
            @(negedge clk_tb);
            if (o_irq2) t2 = cyc_cnt;
        end
        chk("irq2_latency", 32'(t2 - t1), 32'd68);
        r = -1;
        for (int i = 0; i < 10 && r < 0; i++) begin
            if (o_core_rst) r = cyc_cnt; else @(negedge clk_tb);
        end
        chk("core_rst_delay", 32'(r - t2), 32'd1);
        n = 0;
        while (o_core_rst && n < 200) begin
            n++;
            @(negedge clk_tb);
        end
        chk("core_rst_len", 32'(n), 32'd62);
        chk("post_seq_irq", {30'b0, o_irq1, o_irq2}, 32'h0);
        wb_xfer(0, 4'h0, 0, 4'hF, rd); chk("post_seq_csr", rd, 32'h3FF0);
        repeat (20) @(negedge clk_tb);
        wb_xfer(0, 4'h4, 0, 4'hF, rd); chk("post_seq_cnt", rd, 32'h0);

        // sys_rst aborts a running sequence
        wb_xfer(1, 4'h0, 32'h001, 4'hF, rd);
        repeat (20) @(negedge clk_tb);
        chk("abort_pre", 32'(o_core_rst), 32'h1);
        sys_rst = 1;
        repeat (2) @(negedge clk_tb);
        sys_rst = 0;
        @(negedge clk_tb);
        chk("abort_post", 32'(o_core_rst), 32'h0);
        wb_xfer(0, 4'h0, 0, 4'hF, rd); chk("abort_csr", rd, 32'h3FF0);

        // Randomized traffic: byte-masked CSR writes, reads, unmapped offsets, idles
        repeat (40) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    d = $urandom;
                    d[13:4] = 10'($urandom_range(0, 7));
                    d[0] = ($urandom_range(0, 3) != 0);
                    wb_xfer(1, 4'h0, d, 4'($urandom_range(0, 15)), rd);
                end
                1: wb_xfer(0, 4'h0, 0, 4'hF, rd);
                2: wb_xfer(0, 4'h4, 0, 4'hF, rd);
                3: begin
                    a = 4'($urandom_range(1, 15));
                    if (a == 4'h4) a = 4'h8;
                    wb_xfer(1, a, $urandom, 4'hF, rd);
                    wb_xfer(0, a, 0, 4'hF, rd);
                    chk("unmapped_read", rd, 32'h0);
                end
                default: repeat ($urandom_range(0, 30)) @(negedge clk_tb);
            endcase
        end
        sys_rst = 1;
        repeat (2) @(negedge clk_tb);
        sys_rst = 0;

        // Disabled watchdog stays quiet
        wb_xfer(1, 4'h0, 32'h100, 4'hF, rd);
        repeat (20) begin
            repeat (47) @(negedge clk_tb);
            wb_xfer(0, 4'h4, 0, 4'hF, rd);
            chk("dis_cnt", rd, 32'h0);
            chk("dis_irq", {30'b0, o_irq1, o_irq2}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
